gshare_bp: RTL and testbench
============================

GSHARE_BP -- requirements
Module: gshare_bp

Interface
REQ-001 SHALL have parameter BTB_IDX_BITS, default 6, BTB index width (2^6 entries).
REQ-002 SHALL have parameter PHT_IDX_BITS, default 8, PHT index width (2^8 2-bit counters).
REQ-003 SHALL have parameter GHR_BITS, default 8, global history length, legal range 1..PHT_IDX_BITS.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, at least 2.
REQ-005 SHALL provide ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC  in  32  fetch address.
- fetch_valid  in  1  PC is a real fetch this cycle.
- predict_taken  out  1  redirect predicted.
- nextPC  out  32  predicted next fetch address.
- predict_ghr  out  GHR_BITS  history snapshot; the pipeline carries it to resolve.
- update_en  in  1  resolved control-flow instruction.
- update_pc  in  32  address of the resolved instruction.
- update_taken  in  1  actual direction.
- update_target  in  32  actual target.
- update_is_branch  in  1  conditional branch.
- update_is_call  in  1  call.
- update_is_return  in  1  return.
- update_ghr  in  GHR_BITS  snapshot captured at its fetch.
- update_mispredict  in  1  history recovery request; qualified by update_en.

Function
REQ-006 SHALL perform lookup combinationally from PC; BTB index = PC[BTB_IDX_BITS+1:2]; tag = PC[31:BTB_IDX_BITS+2].
REQ-007 SHALL form PHT index = PC[PHT_IDX_BITS+1:2] XOR zero-extended GHR, for both lookup and update (update uses update_pc with update_ghr).
REQ-008 SHALL predict as follows:
- Miss (invalid entry or tag mismatch): not taken, nextPC = PC+4.
- JUMP hit: taken, stored target.
- BRANCH hit: taken with stored target when counter >= 2, else not taken with PC+4.
- RETURN hit: taken with RAS top when the RAS is non-empty, else not taken with PC+4.
REQ-009 SHALL drive predict_ghr = current GHR, combinationally.
REQ-010 SHALL, on fetch_valid with a BRANCH hit, shift the GHR left by one, inserting the predicted direction at bit 0.
REQ-011 SHALL, on update_en && update_mispredict, load the GHR with {update_ghr[GHR_BITS-2:0], update_taken} for a branch, else with update_ghr; this has priority over the REQ-010 shift in the same cycle.
REQ-012 SHALL, on update_en, write the BTB entry with valid, tag and update_target, and set its type: RETURN if update_is_return, else BRANCH if update_is_branch, else JUMP.
REQ-013 SHALL, on update_en && update_is_branch, step the PHT counter +1 when taken or -1 when not taken, saturating at 0 and 3.
REQ-014 SHALL update the RAS non-speculatively at resolve:
- update_is_call pushes update_pc+4.
- update_is_return pops.
- Both asserted together replaces the top entry.
REQ-015 SHALL implement the RAS as circular: a push when full overwrites the oldest entry (count saturates at RAS_DEPTH); a pop when empty is a no-op.
REQ-016 SHALL let a lookup in the same cycle as an update to the same entry see pre-update contents (no bypass); the new contents are visible the next cycle.
REQ-017 SHALL ignore all update_* inputs while update_en = 0.

Reset
REQ-018 SHALL, while rst = 1 (asynchronously):
- clear every BTB valid bit, tag and target;
- set every PHT counter to 1 (weakly not taken);
- clear GHR to 0;
- clear RAS pointer and count to 0.
REQ-019 SHALL, during reset, produce predict_taken = 0, nextPC = PC+4 and predict_ghr = 0; an update in flight when reset asserts is discarded.

Structure
REQ-020 SHALL take from shared package bp_pkg: the BTB type encoding (EMPTY, JUMP, BRANCH, RETURN) and the counter constants SNT=0, WNT=1, WT=2, ST=3.
REQ-021 SHALL instantiate sub-module bp_ras (parameter RAS_DEPTH; push, pop, push data, top, empty outputs).

Verification
REQ-022 SHALL cover: reset, then PC=0x100 -> predict_taken=0, nextPC=0x104, predict_ghr=0.
REQ-023 SHALL cover: jump update at pc=0x200, target 0x400; next cycle PC=0x200 -> taken, nextPC=0x400.
REQ-024 SHALL cover: branch at 0x300, target 0x380, GHR held 0, two taken updates -> counter 1->2->3; lookup taken to 0x380; fetch_valid shifts GHR to 0x01.
REQ-025 SHALL cover: GHR=0x05, mispredict update on a branch (update_ghr=0x02, taken=0) in the same cycle as a fetch shift -> GHR=0x04.
REQ-026 SHALL cover: 5 calls (pc 0x10,0x20,0x30,0x40,0x50) with RAS_DEPTH=4, then a RETURN hit -> nextPC 0x54; after 4 pops the RAS is empty -> return predicts not taken.
REQ-027 SHALL cover: rst pulsed mid-run, asynchronously and between clock edges -> all BTB entries miss and GHR=0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: BTB entry kinds, 2-bit counter constants
// and the saturating counter step.
package bp_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2,
        RETURN = 2'd3
    } btb_type_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            res = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// pops on empty are ignored, push+pop together replaces the top.
module bp_ras #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [31:0]      mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;

    // Pointer/count next state and which slot (if any) gets written.
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q;
        if (push_i && (!pop_i || cnt_q == '0)) begin
            ptr_d    = ptr_q + 1'b1;
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_q + 1'b1;
            cnt_d    = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
        end else if (push_i) begin
            wr_en_s  = 1'b1;
            wr_idx_s = ptr_q;
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en_s) begin
                mem_q[wr_idx_s] <= push_data_i;
            end
        end
    end

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/gshare_bp.sv
// Gshare direction predictor with a direct-mapped BTB and a resolve-time RAS;
// lookup is combinational from PC, all state changes on the rising edge.
module gshare_bp
    import bp_pkg::*;
#(
    parameter int BTB_IDX_BITS = 6,
    parameter int PHT_IDX_BITS = 8,
    parameter int GHR_BITS     = 8,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PC,
    input  logic                fetch_valid,
    output logic                predict_taken,
    output logic [31:0]         nextPC,
    output logic [GHR_BITS-1:0] predict_ghr,
    input  logic                update_en,
    input  logic [31:0]         update_pc,
    input  logic                update_taken,
    input  logic [31:0]         update_target,
    input  logic                update_is_branch,
    input  logic                update_is_call,
    input  logic                update_is_return,
    input  logic [GHR_BITS-1:0] update_ghr,
    input  logic                update_mispredict
);

    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int PHT_N = 1 << PHT_IDX_BITS;
    localparam int TAG_W = 32 - BTB_IDX_BITS - 2;

    logic              valid_q  [BTB_N];
    logic [TAG_W-1:0]  tag_q    [BTB_N];
    logic [31:0]       target_q [BTB_N];
    btb_type_e         type_q   [BTB_N];
    logic [1:0]        pht_q    [PHT_N];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    logic [BTB_IDX_BITS-1:0] lk_idx_s, up_idx_s;
    logic [TAG_W-1:0]        lk_tag_s, up_tag_s;
    logic [PHT_IDX_BITS-1:0] lk_pht_idx_s, up_pht_idx_s;
    logic                    hit_s, branch_hit_s, pred_taken_s;
    logic [31:0]             next_pc_s, pc_plus4_s;
    logic [1:0]              lk_cnt_s;
    btb_type_e               up_type_s;
    logic [31:0]             ras_top_s;
    logic                    ras_empty_s;

    // Shifting history with a new bit works for any GHR_BITS, including 1.
    function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                     input logic b);
        logic [GHR_BITS-1:0] r;
        r    = h << 1;
        r[0] = b;
        return r;
    endfunction

    assign lk_idx_s     = PC[BTB_IDX_BITS+1:2];
    assign lk_tag_s     = PC[31:BTB_IDX_BITS+2];
    assign up_idx_s     = update_pc[BTB_IDX_BITS+1:2];
    assign up_tag_s     = update_pc[31:BTB_IDX_BITS+2];
    assign lk_pht_idx_s = PC[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
    assign up_pht_idx_s = update_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(update_ghr);
    assign pc_plus4_s   = PC + 32'd4;
    assign hit_s        = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    assign lk_cnt_s     = pht_q[lk_pht_idx_s];

    // Prediction from the pre-update BTB/PHT/RAS contents.
    always_comb begin
        pred_taken_s = 1'b0;
        next_pc_s    = pc_plus4_s;
        branch_hit_s = 1'b0;
        if (!rst && hit_s) begin
            case (type_q[lk_idx_s])
                JUMP: begin
                    pred_taken_s = 1'b1;
                    next_pc_s    = target_q[lk_idx_s];
                end
                BRANCH: begin
                    branch_hit_s = 1'b1;
                    if (lk_cnt_s >= WT) begin
                        pred_taken_s = 1'b1;
                        next_pc_s    = target_q[lk_idx_s];
                    end else begin
                        pred_taken_s = 1'b0;
                    end
                end
                RETURN: begin
                    if (!ras_empty_s) begin
                        pred_taken_s = 1'b1;
                        next_pc_s    = ras_top_s;
                    end else begin
                        pred_taken_s = 1'b0;
                    end
                end
                default: begin
                    pred_taken_s = 1'b0;
                end
            endcase
        end else begin
            pred_taken_s = 1'b0;
        end
    end

    assign predict_taken = pred_taken_s;
    assign nextPC        = next_pc_s;
    assign predict_ghr   = ghr_q;

    // Entry kind written on resolve; return wins over branch wins over jump.
    always_comb begin
        if (update_is_return) begin
            up_type_s = RETURN;
        end else if (update_is_branch) begin
            up_type_s = BRANCH;
        end else begin
            up_type_s = JUMP;
        end
    end

    // Recovery from a mispredict overrides the speculative fetch shift.
    always_comb begin
        ghr_d = ghr_q;
        if (update_en && update_mispredict) begin
            ghr_d = update_is_branch ? shift_in(update_ghr, update_taken) : update_ghr;
        end else if (fetch_valid && branch_hit_s) begin
            ghr_d = shift_in(ghr_q, pred_taken_s);
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Global history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // BTB storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                type_q[i]   <= EMPTY;
            end
        end else if (update_en) begin
            valid_q[up_idx_s]  <= 1'b1;
            tag_q[up_idx_s]    <= up_tag_s;
            target_q[up_idx_s] <= update_target;
            type_q[up_idx_s]   <= up_type_s;
        end
    end

    // Pattern history table of 2-bit saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= WNT;
            end
        end else if (update_en && update_is_branch) begin
            pht_q[up_pht_idx_s] <= sat_step(pht_q[up_pht_idx_s], update_taken);
        end
    end

    bp_ras #(
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push_i     (update_en && update_is_call),
        .pop_i      (update_en && update_is_return),
        .push_data_i(update_pc + 32'd4),
        .top_o      (ras_top_s),
        .empty_o    (ras_empty_s)
    );

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp: reset, jump, branch/PHT, GHR recovery,
// RAS and asynchronous reset scenarios.
module tb_gshare_bp;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        fetch_valid;
    logic        predict_taken;
    logic [31:0] nextPC;
    logic [7:0]  predict_ghr;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_is_branch;
    logic        update_is_call;
    logic        update_is_return;
    logic [7:0]  update_ghr;
    logic        update_mispredict;

    int n_checks = 0;
    int n_errors = 0;

    gshare_bp dut (
        .clk              (clk),
        .rst              (rst),
        .PC               (PC),
        .fetch_valid      (fetch_valid),
        .predict_taken    (predict_taken),
        .nextPC           (nextPC),
        .predict_ghr      (predict_ghr),
        .update_en        (update_en),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_is_branch (update_is_branch),
        .update_is_call   (update_is_call),
        .update_is_return (update_is_return),
        .update_ghr       (update_ghr),
        .update_mispredict(update_mispredict)
    );

    always #5 clk = ~clk;

    task automatic clear_update();
        update_en         = 1'b0;
        update_pc         = 32'd0;
        update_taken      = 1'b0;
        update_target     = 32'd0;
        update_is_branch  = 1'b0;
        update_is_call    = 1'b0;
        update_is_return  = 1'b0;
        update_ghr        = 8'd0;
        update_mispredict = 1'b0;
    endtask

    // Called at a negedge; applies one resolve across the next posedge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic br, input logic cl, input logic rt,
                       input logic [7:0] gh, input logic mp);
        update_en         = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_is_branch  = br;
        update_is_call    = cl;
        update_is_return  = rt;
        update_ghr        = gh;
        update_mispredict = mp;
        @(negedge clk);
        clear_update();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        PC = 32'h100;
        fetch_valid = 1'b0;
        clear_update();
        #12;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h104 || predict_ghr !== 8'h00) begin
            n_errors++;
            $display("FAIL in_reset: got taken=%0b next=%h ghr=%h want 0 104 00",
                     predict_taken, nextPC, predict_ghr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h104 || predict_ghr !== 8'h00) begin
            n_errors++;
            $display("FAIL after_reset: got taken=%0b next=%h ghr=%h want 0 104 00",
                     predict_taken, nextPC, predict_ghr);
        end
        @(negedge clk);
    endtask

    task automatic test_jump();
        PC               = 32'h200;
        update_en        = 1'b1;
        update_pc        = 32'h200;
        update_target    = 32'h400;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h204) begin
            n_errors++;
            $display("FAIL jump_no_bypass: got taken=%0b next=%h want 0 204",
                     predict_taken, nextPC);
        end
        @(negedge clk);
        clear_update();
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h400) begin
            n_errors++;
            $display("FAIL jump_hit: got taken=%0b next=%h want 1 400", predict_taken, nextPC);
        end
        update_pc        = 32'h200;
        update_target    = 32'h999;
        update_is_return = 1'b1;
        update_ghr       = 8'h33;
        update_mispredict = 1'b1;
        @(negedge clk);
        clear_update();
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h400 || predict_ghr !== 8'h00) begin
            n_errors++;
            $display("FAIL update_disabled: got taken=%0b next=%h ghr=%h want 1 400 00",
                     predict_taken, nextPC, predict_ghr);
        end
        @(negedge clk);
    endtask

    task automatic test_branch();
        PC = 32'h300;
        for (int i = 0; i < 3; i++) upd(32'h300, 1'b1, 32'h380, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h380) begin
            n_errors++;
            $display("FAIL branch_taken: got taken=%0b next=%h want 1 380", predict_taken, nextPC);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) upd(32'h300, 1'b0, 32'h380, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h304) begin
            n_errors++;
            $display("FAIL branch_saturate: got taken=%0b next=%h want 0 304",
                     predict_taken, nextPC);
        end
        @(negedge clk);
        upd(32'h300, 1'b1, 32'h380, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h380) begin
            n_errors++;
            $display("FAIL branch_retaken: got taken=%0b next=%h want 1 380",
                     predict_taken, nextPC);
        end
        @(negedge clk);
        fetch_valid = 1'b1;
        @(negedge clk);
        fetch_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_ghr !== 8'h01) begin
            n_errors++;
            $display("FAIL ghr_shift: got %h want 01", predict_ghr);
        end
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h304) begin
            n_errors++;
            $display("FAIL pht_xor_index: got taken=%0b next=%h want 0 304",
                     predict_taken, nextPC);
        end
        @(negedge clk);
    endtask

    task automatic test_ghr_recover();
        upd(32'h304, 1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);
        #1;
        n_checks++;
        if (predict_ghr !== 8'h05) begin
            n_errors++;
            $display("FAIL ghr_load: got %h want 05", predict_ghr);
        end
        @(negedge clk);
        PC = 32'h300;
        fetch_valid = 1'b1;
        upd(32'h308, 1'b0, 32'h390, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
        fetch_valid = 1'b0;
        #1;
        n_checks++;
        if (predict_ghr !== 8'h04) begin
            n_errors++;
            $display("FAIL ghr_recover_priority: got %h want 04", predict_ghr);
        end
        @(negedge clk);
    endtask

    task automatic test_ras();
        logic [31:0] exp_top [3];
        exp_top[0] = 32'h44;
        exp_top[1] = 32'h34;
        exp_top[2] = 32'h24;
        upd(32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) upd(32'h10 * k, 1'b1, 32'h800, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        PC = 32'h600;
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h54) begin
            n_errors++;
            $display("FAIL ras_top: got taken=%0b next=%h want 1 54", predict_taken, nextPC);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            upd(32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
            #1;
            n_checks++;
            if (predict_taken !== 1'b1 || nextPC !== exp_top[k]) begin
                n_errors++;
                $display("FAIL ras_pop%0d: got taken=%0b next=%h want 1 %h",
                         k, predict_taken, nextPC, exp_top[k]);
            end
            @(negedge clk);
        end
        upd(32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h604) begin
            n_errors++;
            $display("FAIL ras_empty: got taken=%0b next=%h want 0 604", predict_taken, nextPC);
        end
        @(negedge clk);
        upd(32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        upd(32'h70, 1'b1, 32'h800, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        upd(32'h80, 1'b1, 32'h800, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h84) begin
            n_errors++;
            $display("FAIL ras_replace: got taken=%0b next=%h want 1 84", predict_taken, nextPC);
        end
        @(negedge clk);
        upd(32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h604) begin
            n_errors++;
            $display("FAIL ras_replace_pop: got taken=%0b next=%h want 0 604",
                     predict_taken, nextPC);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        PC = 32'h10;
        #1;
        n_checks++;
        if (predict_taken !== 1'b1 || nextPC !== 32'h800 || predict_ghr !== 8'h04) begin
            n_errors++;
            $display("FAIL pre_async: got taken=%0b next=%h ghr=%h want 1 800 04",
                     predict_taken, nextPC, predict_ghr);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h14 || predict_ghr !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: got taken=%0b next=%h ghr=%h want 0 14 00",
                     predict_taken, nextPC, predict_ghr);
        end
        @(negedge clk);
        rst = 1'b0;
        PC = 32'h300;
        #1;
        n_checks++;
        if (predict_taken !== 1'b0 || nextPC !== 32'h304) begin
            n_errors++;
            $display("FAIL btb_cleared: got taken=%0b next=%h want 0 304", predict_taken, nextPC);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch();
        test_ghr_recover();
        test_ras();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
